// File: rtl/tc_logic_pipe_if.sv
// Handshake bundle for tc_logic_pipe: the input beat with its operands and
// mode controls, and the result stream leaving the output buffer.
interface tc_logic_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [2:0]       op;
    logic             acc_mode;
    logic             acc_clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             out_zero;

    modport master (
        output in_valid, in0, in1, op, acc_mode, acc_clear, out_ready,
        input  in_ready, out_valid, out, out_zero
    );

    modport slave (
        input  in_valid, in0, in1, op, acc_mode, acc_clear, out_ready,
        output in_ready, out_valid, out, out_zero
    );
endinterface

// File: rtl/tc_logic_pipe.sv
// Bitwise logic unit with an optional running accumulator, feeding a
// two-entry result buffer. in_ready is registered so downstream out_ready
// never reaches the upstream handshake combinationally.
module tc_logic_pipe #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    tc_logic_pipe_if.slave    bus
);
    localparam int DEPTH = 2;

    typedef logic [WIDTH-1:0] word_t;

    logic [1:0] r_count;
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic       r_in_ready;
    word_t      r_acc;
    word_t      r_mem [DEPTH];

    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count_next;
    word_t      w_op_a;
    word_t      w_op_b;
    word_t      w_result;

    function automatic word_t f_logic(input logic [2:0] op, input word_t a, input word_t b);
        word_t r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = a;
        endcase
        return r;
    endfunction

    // Operand routing and result selection; accumulate mode uses acc as A and in0 as B.
    always_comb begin
        w_op_a   = bus.acc_mode ? r_acc : bus.in0;
        w_op_b   = bus.acc_mode ? bus.in0 : bus.in1;
        w_result = f_logic(bus.op, w_op_a, w_op_b);
        if (bus.acc_mode && bus.acc_clear) begin
            w_result = bus.in0;
        end
    end

    assign w_push = bus.in_valid && r_in_ready;
    assign w_pop  = (r_count != 2'd0) && bus.out_ready;

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // Buffer control, registered ready and accumulator; acc resets to the AND identity.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_in_ready <= 1'b0;
            r_acc      <= '1;
        end else begin
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != 2'd2);
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
                if (bus.acc_mode) begin
                    r_acc <= w_result;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // Result storage; cleared on reset so the head reads zero while held in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_result;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = (r_count != 2'd0);
    assign bus.out       = r_mem[r_rd_ptr];
    assign bus.out_zero  = bus.out_valid && (bus.out == '0);

endmodule

// File: tb/tb_tc_logic_pipe.sv
// Directed bench for tc_logic_pipe at WIDTH=8, plus a randomized pairwise
// run on WIDTH=1 and WIDTH=32 instances checked against a queue model.
module tb_tc_logic_pipe;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    tc_logic_pipe_if #(.WIDTH(8))  b8 ();
    tc_logic_pipe_if #(.WIDTH(1))  b1 ();
    tc_logic_pipe_if #(.WIDTH(32)) b32 ();

    tc_logic_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(b8));
    tc_logic_pipe #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(b1));
    tc_logic_pipe #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a & b);
            3'd4: return ~(a | b);
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic am, input logic ac, input logic ordy);
        b8.in_valid  = v;
        b8.in0       = a;
        b8.in1       = b;
        b8.op        = op;
        b8.acc_mode  = am;
        b8.acc_clear = ac;
        b8.out_ready = ordy;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_total++; if (b8.in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b exp=0", b8.in_ready); else n_pass++;
        n_total++; if (b8.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", b8.out_valid); else n_pass++;
        n_total++; if (b8.out !== 8'h00) $display("FAIL rst_out got=%h exp=00", b8.out); else n_pass++;
        n_total++; if (b8.out_zero !== 1'b0) $display("FAIL rst_out_zero got=%b exp=0", b8.out_zero); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (b8.in_ready !== 1'b1) $display("FAIL rel_in_ready got=%b exp=1", b8.in_ready); else n_pass++;
        n_total++; if (b8.out_valid !== 1'b0) $display("FAIL rel_out_valid got=%b exp=0", b8.out_valid); else n_pass++;
    endtask

    task automatic test_pairwise();
        logic [7:0] exp_tbl [8];
        exp_tbl = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
        for (int i = 0; i < 8; i++) begin
            drive8(1'b1, 8'hF0, 8'h3C, 3'(i), 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            n_total++;
            if (b8.out_valid !== 1'b1 || b8.out !== exp_tbl[i])
                $display("FAIL pair_op%0d got=%b/%h exp=1/%h", i, b8.out_valid, b8.out, exp_tbl[i]);
            else n_pass++;
        end
        drive8(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        n_total++; if (b8.out_valid !== 1'b0) $display("FAIL pair_drain got=%b exp=0", b8.out_valid); else n_pass++;
    endtask

    task automatic test_accumulate();
        logic [7:0] din  [5];
        logic [2:0] ops  [5];
        logic       clr  [5];
        logic [7:0] expv [5];
        din  = '{8'hFF, 8'h0F, 8'h3C, 8'hA5, 8'hFF};
        ops  = '{3'd0, 3'd0, 3'd0, 3'd5, 3'd2};
        clr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        expv = '{8'hFF, 8'h0F, 8'h0C, 8'hA5, 8'h5A};
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            drive8(1'b1, din[i], 8'h00, ops[i], 1'b1, clr[i], 1'b1);
            @(negedge clk);
            n_total++;
            if (b8.out_valid !== 1'b1 || b8.out !== expv[i] || b8.out_zero !== 1'b0)
                $display("FAIL acc_beat%0d got=%b/%h/%b exp=1/%h/0", i, b8.out_valid, b8.out, b8.out_zero, expv[i]);
            else n_pass++;
        end
        drive8(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        drive8(1'b1, 8'h01, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_total++; if (b8.in_ready !== 1'b1) $display("FAIL bp_ready1 got=%b exp=1", b8.in_ready); else n_pass++;
        b8.in0 = 8'h02;
        @(negedge clk);
        n_total++; if (b8.in_ready !== 1'b0) $display("FAIL bp_full got=%b exp=0", b8.in_ready); else n_pass++;
        b8.in0 = 8'h03;
        @(negedge clk);
        n_total++;
        if (b8.in_ready !== 1'b0 || b8.out_valid !== 1'b1 || b8.out !== 8'h01)
            $display("FAIL bp_hold got=%b/%b/%h exp=0/1/01", b8.in_ready, b8.out_valid, b8.out);
        else n_pass++;
        b8.out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (b8.out !== 8'h02 || b8.in_ready !== 1'b1)
            $display("FAIL bp_pop1 got=%h/%b exp=02/1", b8.out, b8.in_ready);
        else n_pass++;
        @(negedge clk);
        n_total++; if (b8.out_valid !== 1'b1 || b8.out !== 8'h03) $display("FAIL bp_pop2 got=%b/%h exp=1/03", b8.out_valid, b8.out); else n_pass++;
        b8.in_valid = 1'b0;
        @(negedge clk);
        n_total++; if (b8.out_valid !== 1'b0) $display("FAIL bp_empty got=%b exp=0", b8.out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive8(1'b1, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n_total++;
            if (b8.out_valid !== 1'b1 || b8.in_ready !== 1'b1 || b8.out !== 8'(i - 1) || b8.out_zero !== (i == 1))
                $display("FAIL b2b_%0d got=%b/%b/%h/%b exp=1/1/%h/%b", i - 1, b8.out_valid, b8.in_ready,
                         b8.out, b8.out_zero, 8'(i - 1), (i == 1));
            else n_pass++;
            if (i < 10) b8.in0 = 8'(i);
            else b8.in_valid = 1'b0;
        end
        @(negedge clk);
        n_total++; if (b8.out_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", b8.out_valid); else n_pass++;
    endtask

    task automatic test_async_reset();
        pulse_reset();
        drive8(1'b1, 8'hFF, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        b8.in0 = 8'h0F;
        @(negedge clk);
        b8.in0 = 8'h3C;
        b8.out_ready = 1'b0;
        @(negedge clk);
        b8.in_valid = 1'b0;
        n_total++;
        if (b8.out_valid !== 1'b1 || b8.in_ready !== 1'b0 || b8.out !== 8'h0F)
            $display("FAIL ar_pre got=%b/%b/%h exp=1/0/0f", b8.out_valid, b8.in_ready, b8.out);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b0 || b8.out_zero !== 1'b0)
            $display("FAIL ar_immediate got=%b/%b/%b exp=0/0/0", b8.out_valid, b8.in_ready, b8.out_zero);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) $display("FAIL ar_release got=%b/%b exp=1/0", b8.in_ready, b8.out_valid); else n_pass++;
        drive8(1'b1, 8'h55, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        n_total++; if (b8.out_valid !== 1'b1 || b8.out !== 8'h55) $display("FAIL ar_acc got=%b/%h exp=1/55", b8.out_valid, b8.out); else n_pass++;
        b8.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] q32 [$];
        logic        q1  [$];
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        logic        v;
        logic        ordy;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            n_total++;
            if (b32.out_valid !== (q32.size() != 0) || b32.in_ready !== (q32.size() < 2))
                $display("FAIL rnd32_flags cyc=%0d got=%b/%b exp=%b/%b", c, b32.out_valid, b32.in_ready,
                         (q32.size() != 0), (q32.size() < 2));
            else n_pass++;
            n_total++;
            if (b1.out_valid !== (q1.size() != 0) || b1.in_ready !== (q1.size() < 2))
                $display("FAIL rnd1_flags cyc=%0d got=%b/%b exp=%b/%b", c, b1.out_valid, b1.in_ready,
                         (q1.size() != 0), (q1.size() < 2));
            else n_pass++;
            ra   = $urandom;
            rb   = $urandom;
            rop  = 3'($urandom_range(0, 7));
            v    = (c < 280) ? 1'($urandom_range(0, 1)) : 1'b0;
            ordy = (c < 280) ? 1'($urandom_range(0, 1)) : 1'b1;
            b32.in_valid = v; b32.in0 = ra; b32.in1 = rb; b32.op = rop;
            b32.acc_mode = 1'b0; b32.acc_clear = 1'($urandom_range(0, 1)); b32.out_ready = ordy;
            b1.in_valid = v; b1.in0 = ra[0]; b1.in1 = rb[0]; b1.op = rop;
            b1.acc_mode = 1'b0; b1.acc_clear = b32.acc_clear; b1.out_ready = ordy;
            #1;
            if (b32.out_valid && ordy) begin
                n_total++;
                if (b32.out !== q32[0] || b32.out_zero !== (q32[0] == 32'd0))
                    $display("FAIL rnd32_data cyc=%0d got=%h/%b exp=%h/%b", c, b32.out, b32.out_zero, q32[0], (q32[0] == 32'd0));
                else n_pass++;
                void'(q32.pop_front());
            end
            if (b1.out_valid && ordy) begin
                n_total++;
                if (b1.out !== q1[0] || b1.out_zero !== ~q1[0])
                    $display("FAIL rnd1_data cyc=%0d got=%b/%b exp=%b/%b", c, b1.out, b1.out_zero, q1[0], ~q1[0]);
                else n_pass++;
                void'(q1.pop_front());
            end
            if (v && b32.in_ready) q32.push_back(ref_op(rop, ra, rb));
            if (v && b1.in_ready) begin
                rb = ref_op(rop, ra, rb);
                q1.push_back(rb[0]);
            end
        end
        @(negedge clk);
        n_total++;
        if (q32.size() != 0 || q1.size() != 0 || b32.out_valid !== 1'b0 || b1.out_valid !== 1'b0)
            $display("FAIL rnd_drain got=%0d/%0d/%b/%b exp=0/0/0/0", q32.size(), q1.size(), b32.out_valid, b1.out_valid);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        drive8(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        b1.in_valid = 1'b0; b1.in0 = 1'b0; b1.in1 = 1'b0; b1.op = 3'd0;
        b1.acc_mode = 1'b0; b1.acc_clear = 1'b0; b1.out_ready = 1'b0;
        b32.in_valid = 1'b0; b32.in0 = '0; b32.in1 = '0; b32.op = 3'd0;
        b32.acc_mode = 1'b0; b32.acc_clear = 1'b0; b32.out_ready = 1'b0;
        test_reset();
        test_pairwise();
        test_accumulate();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
